// File: rtl/cdb_writeback_arbiter_if.sv
// Writeback bus between the EX pipes (ALU, MEM) and the CDB arbiter, plus the
// CDB/scoreboard outputs it drives toward the operand collector and scoreboard.
interface cdb_writeback_arbiter_if #(
    parameter int unsigned DATA_W = 256
);
    logic              Valid_ALU_CDB;
    logic              Ready_CDB_ALU;
    logic              RegWrite_ALU_CDB;
    logic [2:0]        WriteAddr_ALU_CDB;
    logic [2:0]        HWWarp_ALU_CDB;
    logic [1:0]        ScbID_ALU_CDB;
    logic [31:0]       Instr_ALU_CDB;
    logic [DATA_W-1:0] Data_ALU_CDB;

    logic              Valid_MEM_CDB;
    logic              Ready_CDB_MEM;
    logic              RegWrite_MEM_CDB;
    logic [2:0]        WriteAddr_MEM_CDB;
    logic [2:0]        HWWarp_MEM_CDB;
    logic [1:0]        ScbID_MEM_CDB;
    logic [31:0]       Instr_MEM_CDB;
    logic [DATA_W-1:0] Data_MEM_CDB;

    logic              RegWrite_CDB_OC;
    logic [2:0]        WriteAddr_CDB_OC;
    logic [2:0]        HWWarp_CDB_OC;
    logic [DATA_W-1:0] Data_CDB_OC;
    logic [31:0]       Instr_CDB_OC;
    logic              Clear_CDB_SCB;
    logic [2:0]        HWWarp_CDB_SCB;
    logic [1:0]        ScbID_CDB_SCB;

    modport master (
        output Valid_ALU_CDB, RegWrite_ALU_CDB, WriteAddr_ALU_CDB, HWWarp_ALU_CDB,
        output ScbID_ALU_CDB, Instr_ALU_CDB, Data_ALU_CDB,
        output Valid_MEM_CDB, RegWrite_MEM_CDB, WriteAddr_MEM_CDB, HWWarp_MEM_CDB,
        output ScbID_MEM_CDB, Instr_MEM_CDB, Data_MEM_CDB,
        input  Ready_CDB_ALU, Ready_CDB_MEM,
        input  RegWrite_CDB_OC, WriteAddr_CDB_OC, HWWarp_CDB_OC, Data_CDB_OC, Instr_CDB_OC,
        input  Clear_CDB_SCB, HWWarp_CDB_SCB, ScbID_CDB_SCB
    );

    modport slave (
        input  Valid_ALU_CDB, RegWrite_ALU_CDB, WriteAddr_ALU_CDB, HWWarp_ALU_CDB,
        input  ScbID_ALU_CDB, Instr_ALU_CDB, Data_ALU_CDB,
        input  Valid_MEM_CDB, RegWrite_MEM_CDB, WriteAddr_MEM_CDB, HWWarp_MEM_CDB,
        input  ScbID_MEM_CDB, Instr_MEM_CDB, Data_MEM_CDB,
        output Ready_CDB_ALU, Ready_CDB_MEM,
        output RegWrite_CDB_OC, WriteAddr_CDB_OC, HWWarp_CDB_OC, Data_CDB_OC, Instr_CDB_OC,
        output Clear_CDB_SCB, HWWarp_CDB_SCB, ScbID_CDB_SCB
    );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Buffers ALU and MEM results in per-source FIFOs and grants one per cycle onto
// the CDB (round-robin on contention), releasing the matching scoreboard entry.
module cdb_writeback_arbiter #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                    clk,
    input logic                    rst,
    cdb_writeback_arbiter_if.slave bus
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned NumSrc = 2;

    typedef struct packed {
        logic              reg_write;
        logic [2:0]        write_addr;
        logic [2:0]        hw_warp;
        logic [1:0]        scb_id;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              in_entry [NumSrc];
    entry_t              head     [NumSrc];
    entry_t              fifo_q   [NumSrc][FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q [NumSrc];
    logic [PtrW-1:0]     rd_ptr_q [NumSrc];
    logic [CntW-1:0]     count_q  [NumSrc];
    logic [NumSrc-1:0]   in_valid;
    logic [NumSrc-1:0]   ready;
    logic [NumSrc-1:0]   push;
    logic [NumSrc-1:0]   head_valid;
    logic [NumSrc-1:0]   grant;
    entry_t              sel;

    // rr_q = 0: ALU wins the next two-way contention, 1: MEM wins.
    logic rr_q, rr_d;

    logic              reg_write_q;
    logic              clear_q;
    logic [2:0]        write_addr_q;
    logic [2:0]        hw_warp_q;
    logic [1:0]        scb_id_q;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        in_valid    = {bus.Valid_MEM_CDB, bus.Valid_ALU_CDB};
        in_entry[0] = '{reg_write:  bus.RegWrite_ALU_CDB,
                        write_addr: bus.WriteAddr_ALU_CDB,
                        hw_warp:    bus.HWWarp_ALU_CDB,
                        scb_id:     bus.ScbID_ALU_CDB,
                        instr:      bus.Instr_ALU_CDB,
                        data:       bus.Data_ALU_CDB};
        in_entry[1] = '{reg_write:  bus.RegWrite_MEM_CDB,
                        write_addr: bus.WriteAddr_MEM_CDB,
                        hw_warp:    bus.HWWarp_MEM_CDB,
                        scb_id:     bus.ScbID_MEM_CDB,
                        instr:      bus.Instr_MEM_CDB,
                        data:       bus.Data_MEM_CDB};
    end

    // Ready comes from the registered count only, so a full FIFO refuses input
    // even in a cycle where its head is being granted.
    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            ready[i]      = count_q[i] != CntW'(FIFO_DEPTH);
            push[i]       = in_valid[i] & ready[i];
            head_valid[i] = count_q[i] != '0;
            head[i]       = fifo_q[i][rd_ptr_q[i]];
        end
    end

    always_comb begin
        grant = '0;
        rr_d  = rr_q;
        unique case (head_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                grant = rr_q ? 2'b10 : 2'b01;
                rr_d  = ~rr_q;
            end
            default: grant = '0;
        endcase
        sel = grant[1] ? head[1] : head[0];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NumSrc; i++) begin
            if (push[i]) begin
                fifo_q[i][wr_ptr_q[i]] <= in_entry[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
            for (int i = 0; i < NumSrc; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < NumSrc; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                if (grant[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                unique case ({push[i], grant[i]})
                    2'b10:   count_q[i] <= count_q[i] + CntW'(1);
                    2'b01:   count_q[i] <= count_q[i] - CntW'(1);
                    default: count_q[i] <= count_q[i];
                endcase
            end
        end
    end

    // Strobes last one cycle; the payload fields hold until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            clear_q      <= 1'b0;
            write_addr_q <= '0;
            hw_warp_q    <= '0;
            scb_id_q     <= '0;
            instr_q      <= '0;
            data_q       <= '0;
        end else begin
            clear_q     <= |grant;
            reg_write_q <= (|grant) & sel.reg_write;
            if (|grant) begin
                write_addr_q <= sel.write_addr;
                hw_warp_q    <= sel.hw_warp;
                scb_id_q     <= sel.scb_id;
                instr_q      <= sel.instr;
                data_q       <= sel.data;
            end
        end
    end

    assign bus.Ready_CDB_ALU    = ready[0];
    assign bus.Ready_CDB_MEM    = ready[1];
    assign bus.RegWrite_CDB_OC  = reg_write_q;
    assign bus.WriteAddr_CDB_OC = write_addr_q;
    assign bus.HWWarp_CDB_OC    = hw_warp_q;
    assign bus.Data_CDB_OC      = data_q;
    assign bus.Instr_CDB_OC     = instr_q;
    assign bus.Clear_CDB_SCB    = clear_q;
    assign bus.HWWarp_CDB_SCB   = hw_warp_q;
    assign bus.ScbID_CDB_SCB    = scb_id_q;
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed vector table plus a cycle model
// feeding an expected-result queue for streaming, back-pressure and reset cases.
module tb_cdb_writeback_arbiter;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic              rw;
        logic [2:0]        waddr;
        logic [2:0]        warp;
        logic [1:0]        scb;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct packed {
        logic       rw;
        logic [2:0] waddr;
        logic [2:0] warp;
        logic [1:0] scb;
        logic [7:0] dbyte;
    } src_t;

    typedef struct {
        bit   va;
        src_t a;
        bit   vm;
        src_t m;
        bit   e_clr;
        src_t e;
    } vec_t;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   results;

    ent_t              mq_a[$];
    ent_t              mq_m[$];
    ent_t              exp_q[$];
    bit                rr_m;
    logic [DATA_W-1:0] last_data;

    cdb_writeback_arbiter_if #(.DATA_W(DATA_W)) bus ();

    cdb_writeback_arbiter #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic src_t s(input bit rw, input int a, input int w, input int sc,
                               input logic [7:0] b);
        src_t r;
        r.rw    = rw;
        r.waddr = 3'(a);
        r.warp  = 3'(w);
        r.scb   = 2'(sc);
        r.dbyte = b;
        return r;
    endfunction

    function automatic ent_t from_s(input src_t x);
        ent_t e;
        e.rw    = x.rw;
        e.waddr = x.waddr;
        e.warp  = x.warp;
        e.scb   = x.scb;
        e.instr = {4{x.dbyte}};
        e.data  = {32{x.dbyte}};
        return e;
    endfunction

    function automatic ent_t mk(input int src, input int idx, input int salt);
        ent_t e;
        logic [31:0] w;
        w       = {8'(src), 8'(salt), 16'(idx)};
        e.rw    = (idx % 3) != 2;
        e.waddr = 3'(idx);
        e.warp  = 3'(idx + src * 4);
        e.scb   = 2'(idx);
        e.instr = w;
        e.data  = {8{w}};
        return e;
    endfunction

    function automatic vec_t mkv(input bit va, input src_t a, input bit vm, input src_t m,
                                 input bit c, input src_t e);
        vec_t v;
        v.va = va; v.a = a; v.vm = vm; v.m = m; v.e_clr = c; v.e = e;
        return v;
    endfunction

    task automatic drive(input bit va, input ent_t ea, input bit vm, input ent_t em);
        bus.Valid_ALU_CDB     = va;
        bus.RegWrite_ALU_CDB  = ea.rw;
        bus.WriteAddr_ALU_CDB = ea.waddr;
        bus.HWWarp_ALU_CDB    = ea.warp;
        bus.ScbID_ALU_CDB     = ea.scb;
        bus.Instr_ALU_CDB     = ea.instr;
        bus.Data_ALU_CDB      = ea.data;
        bus.Valid_MEM_CDB     = vm;
        bus.RegWrite_MEM_CDB  = em.rw;
        bus.WriteAddr_MEM_CDB = em.waddr;
        bus.HWWarp_MEM_CDB    = em.warp;
        bus.ScbID_MEM_CDB     = em.scb;
        bus.Instr_MEM_CDB     = em.instr;
        bus.Data_MEM_CDB      = em.data;
    endtask

    // One clock of the reference model; called at posedge+1, returns after the next one.
    task automatic step(input bit va, input ent_t ea, input bit vm, input ent_t em,
                        output bit acc_a, output bit acc_m);
        bit   g_a, g_m, ha, hm;
        ent_t ge;
        drive(va, ea, vm, em);
        check("ready_alu", bus.Ready_CDB_ALU, mq_a.size() != DEPTH);
        check("ready_mem", bus.Ready_CDB_MEM, mq_m.size() != DEPTH);
        acc_a = va && (mq_a.size() != DEPTH);
        acc_m = vm && (mq_m.size() != DEPTH);
        ha = mq_a.size() != 0;
        hm = mq_m.size() != 0;
        if (ha && hm) begin
            g_a  = !rr_m;
            g_m  = rr_m;
            rr_m = !rr_m;
        end else begin
            g_a = ha;
            g_m = hm;
        end
        if (g_a) exp_q.push_back(mq_a.pop_front());
        else if (g_m) exp_q.push_back(mq_m.pop_front());
        if (acc_a) mq_a.push_back(ea);
        if (acc_m) mq_m.push_back(em);
        @(posedge clk);
        #1;
        check("clear_strobe", bus.Clear_CDB_SCB, g_a | g_m);
        if (bus.Clear_CDB_SCB) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got warp %0d scb %0d expected no result",
                         bus.HWWarp_CDB_SCB, bus.ScbID_CDB_SCB);
            end else begin
                ge = exp_q.pop_front();
                results++;
                last_data = ge.data;
                check("regwrite", bus.RegWrite_CDB_OC, ge.rw);
                check("write_addr", bus.WriteAddr_CDB_OC, ge.waddr);
                check("hwwarp_oc", bus.HWWarp_CDB_OC, ge.warp);
                check("hwwarp_scb", bus.HWWarp_CDB_SCB, ge.warp);
                check("scb_id", bus.ScbID_CDB_SCB, ge.scb);
                check("instr", bus.Instr_CDB_OC, ge.instr);
                check("data", bus.Data_CDB_OC, ge.data);
            end
        end else begin
            check("regwrite_idle", bus.RegWrite_CDB_OC, 1'b0);
            check("data_hold", bus.Data_CDB_OC, last_data);
        end
    endtask

    task automatic run_stream(input int na, input int nm, input int mem_mod, input int salt);
        int cyc   = 0;
        int ia    = 0;
        int im    = 0;
        bit aa    = 0;
        bit am    = 0;
        bit vm    = 0;
        bit pend  = 0;
        results = 0;
        while ((ia < na || im < nm || mq_a.size() != 0 || mq_m.size() != 0) && cyc < 300) begin
            // A presented-but-refused MEM result stays valid until taken.
            vm = (im < nm) && (pend || mem_mod == 0 || (cyc % mem_mod) != 0);
            step(ia < na, mk(0, ia, salt), vm, mk(1, im, salt), aa, am);
            pend = vm && !am;
            if (aa) ia++;
            if (am) im++;
            cyc++;
        end
        check("stream_in_budget", cyc < 300, 1'b1);
        check("stream_result_count", results, na + nm);
        check("stream_nothing_pending", exp_q.size(), 0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases after one edge.
    task automatic pulse_reset();
        drive(1'b0, '0, 1'b0, '0);
        #2 rst = 1'b0;
        #1;
        check("rst_clear", bus.Clear_CDB_SCB, 1'b0);
        check("rst_regwrite", bus.RegWrite_CDB_OC, 1'b0);
        check("rst_waddr", bus.WriteAddr_CDB_OC, 3'd0);
        check("rst_warp", bus.HWWarp_CDB_OC, 3'd0);
        check("rst_scb", bus.ScbID_CDB_SCB, 2'd0);
        check("rst_instr", bus.Instr_CDB_OC, 32'd0);
        check("rst_data", bus.Data_CDB_OC, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("rst_ready_alu", bus.Ready_CDB_ALU, 1'b1);
        check("rst_ready_mem", bus.Ready_CDB_MEM, 1'b1);
        mq_a.delete();
        mq_m.delete();
        exp_q.delete();
        rr_m      = 1'b0;
        last_data = '0;
    endtask

    initial begin
        vec_t tbl[10];
        src_t z;
        bit   aa, am;
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        z      = '0;
        rr_m      = 1'b0;
        last_data = '0;
        tbl[0] = mkv(1, s(1, 5, 3, 2, 8'hA5), 0, z, 0, z);
        tbl[1] = mkv(0, z, 0, z, 1, s(1, 5, 3, 2, 8'hA5));
        tbl[2] = mkv(0, z, 0, z, 0, z);
        tbl[3] = mkv(0, z, 1, s(0, 7, 1, 0, 8'h3C), 0, z);
        tbl[4] = mkv(0, z, 0, z, 1, s(0, 7, 1, 0, 8'h3C));
        tbl[5] = mkv(0, z, 0, z, 0, z);
        tbl[6] = mkv(1, s(1, 1, 2, 1, 8'h11), 1, s(1, 6, 4, 3, 8'h22), 0, z);
        tbl[7] = mkv(0, z, 0, z, 1, s(1, 1, 2, 1, 8'h11));
        tbl[8] = mkv(0, z, 0, z, 1, s(1, 6, 4, 3, 8'h22));
        tbl[9] = mkv(0, z, 0, z, 0, z);

        pulse_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].va, from_s(tbl[i].a), tbl[i].vm, from_s(tbl[i].m));
            check($sformatf("tbl%0d_ready_alu", i), bus.Ready_CDB_ALU, 1'b1);
            check($sformatf("tbl%0d_ready_mem", i), bus.Ready_CDB_MEM, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_clear", i), bus.Clear_CDB_SCB, tbl[i].e_clr);
            check($sformatf("tbl%0d_regwrite", i), bus.RegWrite_CDB_OC,
                  tbl[i].e_clr & tbl[i].e.rw);
            if (tbl[i].e_clr) begin
                check($sformatf("tbl%0d_waddr", i), bus.WriteAddr_CDB_OC, tbl[i].e.waddr);
                check($sformatf("tbl%0d_warp", i), bus.HWWarp_CDB_OC, tbl[i].e.warp);
                check($sformatf("tbl%0d_warp_scb", i), bus.HWWarp_CDB_SCB, tbl[i].e.warp);
                check($sformatf("tbl%0d_scb", i), bus.ScbID_CDB_SCB, tbl[i].e.scb);
                check($sformatf("tbl%0d_instr", i), bus.Instr_CDB_OC, {4{tbl[i].e.dbyte}});
                check($sformatf("tbl%0d_data", i), bus.Data_CDB_OC, {32{tbl[i].e.dbyte}});
            end
        end

        pulse_reset();
        // Both pipes saturated: grants alternate and both FIFOs back-pressure.
        run_stream(10, 10, 0, 3);
        // ALU saturated against an intermittent MEM stream.
        run_stream(8, 8, 3, 5);

        // Build up buffered entries, then reset in the middle of the cycle.
        for (int k = 0; k < 3; k++) step(1'b1, mk(0, 40 + k, 6), 1'b1, mk(1, 40 + k, 6), aa, am);
        pulse_reset();
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, '0, aa, am);
        step(1'b1, from_s(s(1, 5, 3, 2, 8'hA5)), 1'b0, '0, aa, am);
        for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b0, '0, aa, am);
        check("final_nothing_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
